// File: rtl/trig_decode.sv
// Trigger-link receiver: link lock tracking, trigger decode, token FIFO and saturating error counters.
// Define TRIG_DECODE_SEQCHK_EN to enable the token sequence check and seq_err_cnt.
module trig_decode #(
    parameter int unsigned LOCK_COMMAS = 16,
    parameter int unsigned ERR_LIMIT   = 4,
    parameter int unsigned FIFO_AW     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] trg_data_i,
    input  logic        kchar_i,
    input  logic        cnt_clr,
    output logic        link_ok,
    output logic        trg_pulse,
    output logic [14:0] trg_token,
    output logic [14:0] fifo_dout,
    output logic        fifo_valid,
    input  logic        fifo_rd,
    output logic [15:0] sym_err_cnt,
    output logic [15:0] seq_err_cnt,
    output logic [15:0] ovf_cnt
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [7:0] LockLast = 8'(LOCK_COMMAS - 1);
    localparam logic [3:0] ErrLast = 4'(ERR_LIMIT - 1);
    localparam logic [FIFO_AW:0] DepthCnt = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] CntOne = 1;
    localparam logic [FIFO_AW-1:0] PtrOne = 1;

    typedef enum logic [1:0] {SymBad, SymComma, SymTrig} sym_e;
    typedef enum logic {StHunt, StLocked} state_e;

    logic [1:0]  rst_sync_q;
    logic [15:0] data1_q;
    logic        k1_q;
    sym_e        sym_q;
    logic [14:0] tok2_q;

    state_e      state_q;
    logic [7:0]  comma_cnt_q;
    logic [3:0]  bad_cnt_q;
    logic        pulse_q;
    logic [14:0] token_q;
    logic [15:0] sym_err_q;
    logic [15:0] ovf_q;

    logic [14:0]        mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               fresh_q, fresh_d;
    logic               trig_acc, full, do_wr, do_rd, ovf_hit, valid;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Deassertion is synchronised; the FSM may not leave HUNT until it has propagated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1_q <= '0;
            k1_q    <= 1'b0;
            sym_q   <= SymBad;
            tok2_q  <= '0;
        end else begin
            data1_q <= trg_data_i;
            k1_q    <= kchar_i;
            tok2_q  <= data1_q[14:0];
            if (k1_q && data1_q == 16'h00BC)  sym_q <= SymComma;
            else if (!k1_q && data1_q[15])    sym_q <= SymTrig;
            else                              sym_q <= SymBad;
        end
    end

    // FIFO control; a word written into an empty FIFO is hidden for one clock.
    always_comb begin
        trig_acc = (state_q == StLocked) && (sym_q == SymTrig);
        valid    = (cnt_q != '0) && !fresh_q;
        do_rd    = fifo_rd && valid;
        full     = (cnt_q == DepthCnt);
        do_wr    = trig_acc && (!full || do_rd);
        ovf_hit  = trig_acc && full && !do_rd;
        cnt_d    = cnt_q;
        if (do_wr && !do_rd)      cnt_d = cnt_q + CntOne;
        else if (!do_wr && do_rd) cnt_d = cnt_q - CntOne;
        fresh_d  = do_wr && (cnt_q == (do_rd ? CntOne : '0));
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= tok2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            fresh_q  <= 1'b0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PtrOne;
            cnt_q   <= cnt_d;
            fresh_q <= fresh_d;
        end
    end

`ifdef TRIG_DECODE_SEQCHK_EN
    logic [14:0] exp_q;
    logic        exp_valid_q;
    logic [15:0] seq_err_q;
    assign seq_err_cnt = seq_err_q;
`else
    assign seq_err_cnt = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            comma_cnt_q <= '0;
            bad_cnt_q   <= '0;
            pulse_q     <= 1'b0;
            token_q     <= '0;
            sym_err_q   <= '0;
            ovf_q       <= '0;
`ifdef TRIG_DECODE_SEQCHK_EN
            exp_q       <= '0;
            exp_valid_q <= 1'b0;
            seq_err_q   <= '0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                StHunt: begin
                    if (rst_sync_q[1]) begin
                        if (sym_q == SymComma) begin
                            if (comma_cnt_q == LockLast) begin
                                state_q     <= StLocked;
                                comma_cnt_q <= '0;
                                bad_cnt_q   <= '0;
                            end else begin
                                comma_cnt_q <= comma_cnt_q + 8'd1;
                            end
                        end else begin
                            comma_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    case (sym_q)
                        SymComma: bad_cnt_q <= '0;
                        SymTrig: begin
                            bad_cnt_q <= '0;
                            pulse_q   <= 1'b1;
                            token_q   <= tok2_q;
`ifdef TRIG_DECODE_SEQCHK_EN
                            if (exp_valid_q && tok2_q != exp_q) seq_err_q <= sat_inc(seq_err_q);
                            exp_q       <= tok2_q + 15'd1;
                            exp_valid_q <= 1'b1;
`endif
                        end
                        default: begin
                            sym_err_q <= sat_inc(sym_err_q);
                            if (bad_cnt_q == ErrLast) begin
                                state_q     <= StHunt;
                                bad_cnt_q   <= '0;
                                comma_cnt_q <= '0;
`ifdef TRIG_DECODE_SEQCHK_EN
                                exp_valid_q <= 1'b0;
`endif
                            end else begin
                                bad_cnt_q <= bad_cnt_q + 4'd1;
                            end
                        end
                    endcase
                end
            endcase
            if (ovf_hit) ovf_q <= sat_inc(ovf_q);
            // Clear wins over any increment on the same edge.
            if (cnt_clr) begin
                sym_err_q <= '0;
                ovf_q     <= '0;
`ifdef TRIG_DECODE_SEQCHK_EN
                seq_err_q <= '0;
`endif
            end
        end
    end

    assign link_ok     = (state_q == StLocked);
    assign trg_pulse   = pulse_q;
    assign trg_token   = token_q;
    assign fifo_valid  = valid;
    assign fifo_dout   = valid ? mem_q[rd_ptr_q] : '0;
    assign sym_err_cnt = sym_err_q;
    assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_trig_decode.sv
// Directed, table-driven bench for trig_decode (default parameters).
module tb_trig_decode;

    localparam logic [15:0] C   = 16'h00BC;
    localparam logic [15:0] BAD = 16'h1234;
`ifdef TRIG_DECODE_SEQCHK_EN
    localparam logic [15:0] SEQ_EXP = 16'd1;
`else
    localparam logic [15:0] SEQ_EXP = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] trg_data_i;
    logic        kchar_i, cnt_clr, fifo_rd;
    logic        link_ok, trg_pulse, fifo_valid;
    logic [14:0] trg_token, fifo_dout;
    logic [15:0] sym_err_cnt, seq_err_cnt, ovf_cnt;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    trig_decode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trg_data_i (trg_data_i),
        .kchar_i    (kchar_i),
        .cnt_clr    (cnt_clr),
        .link_ok    (link_ok),
        .trg_pulse  (trg_pulse),
        .trg_token  (trg_token),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .fifo_rd    (fifo_rd),
        .sym_err_cnt(sym_err_cnt),
        .seq_err_cnt(seq_err_cnt),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        k;
        logic        rd;
        logic        link;
        logic        pulse;
        logic [14:0] tok;
        logic        valid;
        logic [14:0] dout;
        logic [15:0] sym;
    } vec_t;

    vec_t vecs [25];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic [15:0] d, input logic k, input logic rd, input logic clr);
        @(negedge clk);
        trg_data_i = d;
        kchar_i    = k;
        fifo_rd    = rd;
        cnt_clr    = clr;
        @(posedge clk);
        #1;
        if (trg_pulse) pulse_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        trg_data_i = '0;
        kchar_i = 1'b0;
        fifo_rd = 1'b0;
        cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_cnt = 0;
    endtask

    task automatic lock();
        do_reset();
        repeat (18) cyc(C, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [14:0] drain_exp [16];

        vecs[0]  = '{16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'd0};
        vecs[1]  = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'd0};
        vecs[2]  = '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 15'h7FFE, 1'b0, 15'h0000, 16'd0};
        vecs[3]  = '{16'h8002, 1'b0, 1'b0, 1'b1, 1'b1, 15'h7FFF, 1'b1, 15'h7FFE, 16'd0};
        vecs[4]  = '{C,        1'b1, 1'b1, 1'b1, 1'b1, 15'h0000, 1'b1, 15'h7FFF, 16'd0};
        vecs[5]  = '{C,        1'b1, 1'b1, 1'b1, 1'b1, 15'h0002, 1'b1, 15'h0000, 16'd0};
        vecs[6]  = '{C,        1'b1, 1'b1, 1'b1, 1'b0, 15'h0002, 1'b1, 15'h0002, 16'd0};
        vecs[7]  = '{C,        1'b1, 1'b1, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd0};
        vecs[8]  = '{C,        1'b1, 1'b1, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd0};
        vecs[9]  = '{BAD,      1'b0, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd0};
        vecs[10] = '{BAD,      1'b0, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd0};
        vecs[11] = '{BAD,      1'b0, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd1};
        vecs[12] = '{C,        1'b1, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd2};
        vecs[13] = '{C,        1'b1, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd3};
        vecs[14] = '{C,        1'b1, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd3};
        vecs[15] = '{BAD,      1'b0, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd3};
        vecs[16] = '{BAD,      1'b0, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd3};
        vecs[17] = '{BAD,      1'b0, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd4};
        vecs[18] = '{BAD,      1'b0, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd5};
        vecs[19] = '{C,        1'b1, 1'b0, 1'b1, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd6};
        vecs[20] = '{C,        1'b1, 1'b0, 1'b0, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd7};
        vecs[21] = '{C,        1'b1, 1'b0, 1'b0, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd7};
        vecs[22] = '{16'h8003, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd7};
        vecs[23] = '{C,        1'b1, 1'b0, 1'b0, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd7};
        vecs[24] = '{C,        1'b1, 1'b0, 1'b0, 1'b0, 15'h0002, 1'b0, 15'h0000, 16'd7};

        for (int i = 0; i < 15; i++) drain_exp[i] = 15'(i + 1);
        drain_exp[15] = 15'd20;

        rst_n = 1'b0;
        trg_data_i = '0;
        kchar_i = 1'b0;
        cnt_clr = 1'b0;
        fifo_rd = 1'b0;

        // Reset state, then lock on 16 commas and decode TRIG 0x8005.
        do_reset();
        #1;
        check("reset_state", {link_ok, trg_pulse, trg_token, fifo_dout, fifo_valid,
                              sym_err_cnt, seq_err_cnt, ovf_cnt}, 64'd0);
        repeat (16) cyc(C, 1'b1, 1'b0, 1'b0);
        cyc(16'h8005, 1'b0, 1'b0, 1'b0);
        check("link_before_16th", link_ok, 1'b0);
        cyc(C, 1'b1, 1'b0, 1'b0);
        check("link_after_16th", {link_ok, trg_pulse}, 2'b10);
        cyc(C, 1'b1, 1'b0, 1'b0);
        check("first_pulse", {trg_pulse, trg_token, fifo_valid}, {1'b1, 15'h0005, 1'b0});
        cyc(C, 1'b1, 1'b0, 1'b0);
        check("first_fifo", {trg_pulse, trg_token, fifo_valid, fifo_dout},
              {1'b0, 15'h0005, 1'b1, 15'h0005});

        // Only 15 commas before a trigger: no lock, trigger ignored.
        do_reset();
        repeat (15) cyc(C, 1'b1, 1'b0, 1'b0);
        cyc(16'h8001, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc(C, 1'b1, 1'b0, 1'b0);
        check("no_lock_15", {link_ok, fifo_valid, ovf_cnt}, 18'd0);
        check("no_lock_pulses", pulse_cnt, 0);

        // Table: sequence wrap, FIFO read-through, bad symbols and lock loss.
        lock();
        for (int i = 0; i < 25; i++) begin
            cyc(vecs[i].data, vecs[i].k, vecs[i].rd, 1'b0);
            check($sformatf("vec%0d", i),
                  {link_ok, trg_pulse, trg_token, fifo_valid, fifo_dout, sym_err_cnt},
                  {vecs[i].link, vecs[i].pulse, vecs[i].tok, vecs[i].valid,
                   vecs[i].dout, vecs[i].sym});
        end
        check("seq_err_wrap", seq_err_cnt, SEQ_EXP);

        // Overflow: 20 triggers into a 16-deep FIFO, then write+read while full.
        lock();
        for (int i = 0; i < 20; i++) cyc(16'h8000 | 16'(i), 1'b0, 1'b0, 1'b0);
        cyc(16'h8014, 1'b0, 1'b0, 1'b0);
        cyc(C, 1'b1, 1'b0, 1'b0);
        check("ovf_pulses", pulse_cnt, 20);
        check("ovf_cnt4", ovf_cnt, 16'd4);
        cyc(C, 1'b1, 1'b1, 1'b0);
        check("full_rw_ovf", {ovf_cnt, fifo_valid, fifo_dout}, {16'd4, 1'b1, 15'd1});
        check("full_rw_pulses", pulse_cnt, 21);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), {fifo_valid, fifo_dout}, {1'b1, drain_exp[i]});
            cyc(C, 1'b1, 1'b1, 1'b0);
        end
        check("drained", {fifo_valid, seq_err_cnt}, 17'd0);

        // cnt_clr on the same edge as a bad-symbol increment.
        lock();
        cyc(BAD, 1'b0, 1'b0, 1'b0);
        cyc(C, 1'b1, 1'b0, 1'b0);
        cyc(C, 1'b1, 1'b0, 1'b0);
        check("sym_one", sym_err_cnt, 16'd1);
        cyc(BAD, 1'b0, 1'b0, 1'b0);
        cyc(C, 1'b1, 1'b0, 1'b0);
        cyc(C, 1'b1, 1'b0, 1'b1);
        check("clr_priority", {link_ok, sym_err_cnt}, {1'b1, 16'd0});
        cyc(C, 1'b1, 1'b0, 1'b0);
        check("clr_hold", sym_err_cnt, 16'd0);

        // Asynchronous reset mid-stream.
        lock();
        cyc(16'h8007, 1'b0, 1'b0, 1'b0);
        repeat (3) cyc(C, 1'b1, 1'b0, 1'b0);
        check("pre_reset", {link_ok, fifo_valid, fifo_dout}, {1'b1, 1'b1, 15'h0007});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {link_ok, trg_pulse, trg_token, fifo_dout, fifo_valid,
                              sym_err_cnt, seq_err_cnt, ovf_cnt}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
